// File: rtl/uart_rx_drain_pkg.sv
// Shared types and constants for the UART receive-drain block.
package uart_rx_drain_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        CLR    = 2'd3
    } state_e;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned ERR_W  = 2;
    localparam int unsigned CNT_W  = 8;

    // m_err bit positions: {framing, parity}
    localparam int unsigned ERR_PARITY_BIT  = 0;
    localparam int unsigned ERR_FRAMING_BIT = 1;

    localparam logic [ADDR_W-1:0] RXDATA_ADDR_DEFAULT = 5'h04;

endpackage

// File: rtl/uart_rx_drain_fifo.sv
// Circular FIFO with wrap-around pointers; head entry reads as zero when empty.
module uart_rx_drain_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == OCC_W'(DEPTH));
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_drain.sv
// Drains received bytes from a UART over APB into a small FIFO for a streaming consumer.
// Define UART_RX_DRAIN_ERRFLAG_EN to capture parity/framing flags and count errored bytes.
module uart_rx_drain
    import uart_rx_drain_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RXDATA_ADDR = RXDATA_ADDR_DEFAULT,
    parameter int unsigned       FIFO_DEPTH  = 4
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              RXRDY,
    input  logic              PARITY_ERR,
    input  logic              FRAMING_ERR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    output logic [DATA_W-1:0] m_data,
    output logic [ERR_W-1:0]  m_err,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  drop_cnt
);

    state_e            state_q, state_d;
    logic              rst_done_q;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;

    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PADDR   = paddr_q;
    assign PWRITE  = 1'b0;
    assign PWDATA  = '0;
    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;

    // APB bus signals are computed for the next state so they come straight from flops.
    always_comb begin
        state_d   = state_q;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        paddr_d   = paddr_q;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_done_q && RXRDY && !fifo_full) begin
                    state_d = SETUP;
                    psel_d  = 1'b1;
                    paddr_d = RXDATA_ADDR;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (PREADY) begin
                    push    = 1'b1;
                    state_d = CLR;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                end
            end
            CLR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // rst_done_q holds IDLE for the first edge after reset release.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q    <= IDLE;
            rst_done_q <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            paddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            paddr_q    <= paddr_d;
        end
    end

`ifdef UART_RX_DRAIN_ERRFLAG_EN
    localparam int unsigned FIFO_W = DATA_W + ERR_W;

    logic [ERR_W-1:0]  err_in;
    logic [FIFO_W-1:0] head;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    always_comb begin
        err_in                  = '0;
        err_in[ERR_FRAMING_BIT] = FRAMING_ERR;
        err_in[ERR_PARITY_BIT]  = PARITY_ERR;
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (push && (err_in != '0) && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign m_data   = head[DATA_W-1:0];
    assign m_err    = head[FIFO_W-1:DATA_W];
    assign drop_cnt = drop_cnt_q;

    uart_rx_drain_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (PCLK),
        .rst_n     (PRESETN),
        .push      (push),
        .push_data ({err_in, PRDATA}),
        .pop       (pop),
        .head_data (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );
`else
    logic err_unused;

    assign err_unused = PARITY_ERR ^ FRAMING_ERR;
    assign m_err      = '0;
    assign drop_cnt   = '0;

    uart_rx_drain_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (PCLK),
        .rst_n     (PRESETN),
        .push      (push),
        .push_data (PRDATA),
        .pop       (pop),
        .head_data (m_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );
`endif

endmodule

// File: tb/tb_uart_rx_drain.sv
// Scoreboard bench for uart_rx_drain: a UART/APB slave model feeds bytes, a monitor checks the stream.
module tb_uart_rx_drain;

    typedef struct {
        logic [7:0] data;
        logic [1:0] err;
    } item_t;

    logic       PCLK = 1'b0;
    logic       PRESETN = 1'b1;
    logic       RXRDY = 1'b0;
    logic       PARITY_ERR = 1'b0;
    logic       FRAMING_ERR = 1'b0;
    logic       PSEL, PENABLE, PWRITE;
    logic [4:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA = 8'h00;
    logic       PREADY = 1'b1;
    logic [7:0] m_data;
    logic [1:0] m_err;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] drop_cnt;

    item_t uart_q[$];
    item_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    n_reads = 0;
    int    drop_exp = 0;
    bit    rnd_pready = 1'b0;
    bit    rnd_mready = 1'b0;

    uart_rx_drain dut (
        .PCLK        (PCLK),
        .PRESETN     (PRESETN),
        .RXRDY       (RXRDY),
        .PARITY_ERR  (PARITY_ERR),
        .FRAMING_ERR (FRAMING_ERR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .m_data      (m_data),
        .m_err       (m_err),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .drop_cnt    (drop_cnt)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flags only reach the consumer when error capture is built in.
    function automatic logic [1:0] exp_err(input logic [1:0] e);
`ifdef UART_RX_DRAIN_ERRFLAG_EN
        return e;
`else
        return 2'b00;
`endif
    endfunction

    // UART receive holding register plus APB slave: a completed read clears RXRDY,
    // then the next queued byte (if any) is loaded.
    initial begin : uart_model
        item_t it;
        bit    rd;
        forever begin
            @(negedge PCLK);
            rd = PSEL && PENABLE && PREADY;
            if (rd) begin
                n_reads++;
                chk("read_only_when_pending", 32'(RXRDY), 32'd1);
            end
            @(posedge PCLK);
            #1;
            if (rd) RXRDY = 1'b0;
            if (!RXRDY && uart_q.size() > 0) begin
                it = uart_q.pop_front();
                PRDATA = it.data;
                {FRAMING_ERR, PARITY_ERR} = it.err;
                RXRDY = 1'b1;
                exp_q.push_back('{data: it.data, err: exp_err(it.err)});
            end
            if (rnd_pready) PREADY = ($urandom_range(0, 2) != 0);
            if (rnd_mready) m_ready = ($urandom_range(0, 1) != 0);
        end
    end

    initial begin : monitor
        item_t      e;
        bit         hold = 1'b0;
        logic [7:0] hd = 8'h00;
        logic [1:0] he = 2'b00;
        forever begin
            @(negedge PCLK);
            if (!PRESETN) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", 32'(m_data), 32'(hd));
                chk("stall_err", 32'(m_err), 32'(he));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(m_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(m_data), 32'(e.data));
                    chk("out_err", 32'(m_err), 32'(e.err));
                    if (e.err != 2'b00 && drop_exp < 255) drop_exp++;
                end
            end
            hold = m_valid && !m_ready;
            hd   = m_data;
            he   = m_err;
        end
    end

    task automatic wait_drain(input string name, input int max_cyc);
        int t = 0;
        while (t < max_cyc && !(uart_q.size() == 0 && exp_q.size() == 0 &&
                                !RXRDY && !m_valid && !PSEL)) begin
            @(negedge PCLK);
            t++;
        end
        chk({name, "_drain_in_time"}, 32'(t < max_cyc), 32'd1);
    endtask

    task automatic wait_penable(input string name, input int max_cyc);
        int t = 0;
        while (t < max_cyc && !PENABLE) begin
            @(negedge PCLK);
            t++;
        end
        chk({name, "_reach_access"}, 32'(PENABLE), 32'd1);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int    r0;
        int    t;
        item_t it;

        #2 PRESETN = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'h00);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'h00);
        chk("rst_m_err", 32'(m_err), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_pwdata", 32'(PWDATA), 32'h00);
        #2 PRESETN = 1'b1;
        repeat (2) @(negedge PCLK);

        // Single byte with latency and APB phase checks.
        r0 = n_reads;
        uart_q.push_back('{data: 8'hA5, err: 2'b00});
        t = 0;
        while (t < 20 && !RXRDY) begin
            @(negedge PCLK);
            t++;
        end
        chk("single_rxrdy_seen", 32'(RXRDY), 32'd1);
        @(negedge PCLK);
        chk("setup_psel", 32'(PSEL), 32'd1);
        chk("setup_penable", 32'(PENABLE), 32'd0);
        chk("setup_paddr", 32'(PADDR), 32'h04);
        chk("setup_pwrite", 32'(PWRITE), 32'd0);
        @(negedge PCLK);
        chk("access_psel", 32'(PSEL), 32'd1);
        chk("access_penable", 32'(PENABLE), 32'd1);
        chk("access_no_valid_yet", 32'(m_valid), 32'd0);
        @(negedge PCLK);
        chk("latency_m_valid", 32'(m_valid), 32'd1);
        chk("latency_m_data", 32'(m_data), 32'hA5);
        wait_drain("single", 50);
        chk("single_reads", 32'(n_reads - r0), 32'd1);

        // Three wait states in ACCESS.
        @(posedge PCLK);
        #1 PREADY = 1'b0;
        r0 = n_reads;
        uart_q.push_back('{data: 8'h5A, err: 2'b00});
        wait_penable("ws", 20);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge PCLK);
            chk("ws_psel", 32'(PSEL), 32'd1);
            chk("ws_penable", 32'(PENABLE), 32'd1);
            chk("ws_paddr", 32'(PADDR), 32'h04);
            chk("ws_no_push", 32'(m_valid), 32'd0);
        end
        @(posedge PCLK);
        #1 PREADY = 1'b1;
        wait_drain("ws", 50);
        chk("ws_reads", 32'(n_reads - r0), 32'd1);

        // Backpressure: depth 4, five bytes; the fifth stays pending until space frees.
        @(posedge PCLK);
        #1 m_ready = 1'b0;
        r0 = n_reads;
        for (int i = 0; i < 5; i++) uart_q.push_back('{data: 8'(8'hB0 + i), err: 2'b00});
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (i >= 30) chk("full_no_psel", 32'(PSEL), 32'd0);
        end
        chk("full_reads", 32'(n_reads - r0), 32'd4);
        chk("full_rxrdy_pending", 32'(RXRDY), 32'd1);
        chk("full_head", 32'(m_data), 32'hB0);
        @(posedge PCLK);
        #1 m_ready = 1'b1;
        wait_drain("full", 100);
        chk("full_total_reads", 32'(n_reads - r0), 32'd5);

        // Error flag capture: parity, framing, both.
        uart_q.push_back('{data: 8'h3C, err: 2'b01});
        wait_drain("err_par", 50);
        chk("err_drop_cnt_1", 32'(drop_cnt), 32'(drop_exp));
        uart_q.push_back('{data: 8'hC3, err: 2'b10});
        uart_q.push_back('{data: 8'h99, err: 2'b11});
        uart_q.push_back('{data: 8'h11, err: 2'b00});
        wait_drain("err_mix", 80);
        chk("err_drop_cnt_3", 32'(drop_cnt), 32'(drop_exp));

        // Reset while stalled in ACCESS with a byte already buffered.
        @(posedge PCLK);
        #1 m_ready = 1'b0;
        uart_q.push_back('{data: 8'h66, err: 2'b00});
        uart_q.push_back('{data: 8'h77, err: 2'b00});
        t = 0;
        while (t < 30 && !m_valid) begin
            @(negedge PCLK);
            t++;
        end
        chk("rst_mid_buffered", 32'(m_valid), 32'd1);
        @(posedge PCLK);
        #1 PREADY = 1'b0;
        wait_penable("rst_mid", 20);
        #3 PRESETN = 1'b0;
        #1;
        chk("rst_mid_psel", 32'(PSEL), 32'd0);
        chk("rst_mid_penable", 32'(PENABLE), 32'd0);
        chk("rst_mid_paddr", 32'(PADDR), 32'h00);
        chk("rst_mid_m_valid", 32'(m_valid), 32'd0);
        chk("rst_mid_m_data", 32'(m_data), 32'h00);
        chk("rst_mid_drop_cnt", 32'(drop_cnt), 32'd0);
        if (exp_q.size() > 0) it = exp_q.pop_front();
        drop_exp = 0;
        m_ready  = 1'b1;
        PREADY   = 1'b1;
        @(negedge PCLK);
        #2 PRESETN = 1'b1;
        @(negedge PCLK);
        chk("rel_first_edge_idle", 32'(PSEL), 32'd0);
        @(negedge PCLK);
        chk("rel_second_edge_setup", 32'(PSEL), 32'd1);
        wait_drain("rst_mid", 50);
        chk("rst_mid_drop_after", 32'(drop_cnt), 32'd0);

        // Wrap-around with back-to-back push and pop.
        r0 = n_reads;
        for (int i = 0; i < 20; i++) uart_q.push_back('{data: 8'(i), err: 2'b00});
        wait_drain("wrap", 200);
        chk("wrap_reads", 32'(n_reads - r0), 32'd20);

        // Random traffic; enough errored bytes to saturate the drop counter.
        rnd_pready = 1'b1;
        rnd_mready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            it.data = 8'($urandom);
            it.err  = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            uart_q.push_back(it);
        end
        wait_drain("random", 20000);
        rnd_pready = 1'b0;
        rnd_mready = 1'b0;
        @(posedge PCLK);
        #1;
        PREADY  = 1'b1;
        m_ready = 1'b1;
        @(negedge PCLK);
        chk("random_drop_cnt", 32'(drop_cnt), 32'(drop_exp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
